// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared width constants for the registered ripple-carry adder
//
// Purpose : single source for the operand width default and the derived
//           result width used by the adder, its interface and the bench.
// Ports   : none (package).
package full_adder_pkg;

  localparam int WIDTH = 16;
  localparam int SUM_W = WIDTH + 1;

endpackage

// File: rtl/full_adder_dff_16bits_if.sv
// rtl/full_adder_dff_16bits_if.sv - operand/result bundle for the registered adder
//
// Purpose : groups the operand and result signals of full_adder_dff_16bits so
//           a driver and the adder side can be connected as one bundle.
// Signals : a, b   - WIDTH-bit unsigned operands
//           cin    - carry-in
//           sum    - WIDTH+1-bit registered result, MSB is carry-out
// Modports: master drives operands and observes sum; slave is the adder side.
interface full_adder_dff_16bits_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = full_adder_pkg::WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum;

  modport master (
    output a,
    output b,
    output cin,
    input  sum
  );

  modport slave (
    input  a,
    input  b,
    input  cin,
    output sum
  );

endinterface

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - one-bit full-adder cell of the ripple chain
//
// Purpose : s = a ^ b ^ cin, cout = majority(a, b, cin).
// Ports   : a, b, cin - single-bit addends and carry-in
//           s         - sum bit
//           cout      - carry-out to the next cell
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_dff_16bits.sv
// rtl/full_adder_dff_16bits.sv - ripple-carry adder with registered WIDTH+1-bit result
//
// Purpose : sum = a + b + cin through WIDTH full_adder_1bit cells, captured on
//           every rising clk edge; 1-cycle latency, one operand set per cycle.
//           Build option FULL_ADDER_INPUT_REG_EN registers a, b and cin ahead
//           of the chain, making the latency 2 cycles.
// Ports   : sum   - WIDTH+1-bit registered result, MSB is carry-out
//           a, b  - WIDTH-bit unsigned operands
//           cin   - carry-in
//           clk   - rising-edge clock
//           reset - asynchronous active-low reset, clears every register
module full_adder_dff_16bits #(
  parameter int WIDTH = full_adder_pkg::WIDTH
) (
  output logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             reset
);

  import full_adder_pkg::*;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef FULL_ADDER_INPUT_REG_EN
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic             cin_d, cin_q;

  always_comb begin
    a_d   = a;
    b_d   = b;
    cin_d = cin;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  // carry[i] enters cell i; carry[WIDTH] leaves the last cell as the result MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = op_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1bit u_cell (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (carry[i]),
      .s    (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  logic [WIDTH:0] sum_d, sum_q;

  always_comb begin
    sum_d = {carry[WIDTH], sum_bits};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_full_adder_dff_16bits.sv
// tb/tb_full_adder_dff_16bits.sv - directed and streaming checks of the registered adder
module tb_full_adder_dff_16bits;

  localparam int W = 16;
`ifdef FULL_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  full_adder_dff_16bits_if #(.WIDTH(W)) bus ();

  full_adder_dff_16bits #(.WIDTH(W)) dut (
    .sum   (bus.sum),
    .a     (bus.a),
    .b     (bus.b),
    .cin   (bus.cin),
    .clk   (clk),
    .reset (reset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-result pipeline: pipe[LAT-1] is what sum should show after an edge.
  logic [W:0] pipe [0:1];

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a   = a;
    bus.b   = b;
    bus.cin = c;
  endtask

  task automatic clear_pipe();
    pipe[0] = '0;
    pipe[1] = '0;
  endtask

  // Advance one rising edge, update the model, then settle 2 ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      pipe[1] = pipe[0];
      pipe[0] = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
    end else begin
      clear_pipe();
    end
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    clear_pipe();
    reset = 1'b1;
    drive(16'h0005, 16'h0003, 1'b0);
    repeat (LAT) tick();
    check_eq("pre_reset_sum", bus.sum, 17'h00008);

    // Asynchronous clear between edges.
    #1 reset = 1'b0;
    clear_pipe();
    #1 check_eq("reset_async", bus.sum, 17'h00000);

    drive(16'h1234, 16'h1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset_hold", bus.sum, 17'h00000);
    end

    reset = 1'b1;
    drive(16'hFFFF, 16'h0001, 1'b0);
    repeat (LAT) tick();
    check_eq("carry_out", bus.sum, 17'h10000);

    drive(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (LAT) tick();
    check_eq("wrap_max", bus.sum, 17'h1FFFF);

    drive(16'h0000, 16'h0000, 1'b0);
    repeat (LAT) tick();
    check_eq("all_zero", bus.sum, 17'h00000);

    drive(16'h8000, 16'h8000, 1'b0);
    tick();
`ifdef FULL_ADDER_INPUT_REG_EN
    check_eq("in_reg_first_edge", bus.sum, 17'h00000);
    tick();
`endif
    check_eq("msb_carry", bus.sum, 17'h10000);

    drive(16'h0001, 16'h0002, 1'b0);
    repeat (LAT) tick();
    check_eq("small_sum", bus.sum, 17'h00003);
    drive(16'h0100, 16'h0200, 1'b1);
    #3 check_eq("hold_between_edges", bus.sum, 17'h00003);

    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      drive(ra, rb, 1'b0);
      tick();
      check_eq("stream", bus.sum, pipe[LAT-1]);
    end

    // Mid-stream reset discards in-flight results.
    ra = W'($urandom);
    rb = W'($urandom);
    drive(ra, rb, 1'b0);
    #1 reset = 1'b0;
    clear_pipe();
    #1 check_eq("mid_reset_async", bus.sum, 17'h00000);
    drive(16'h0F0F, 16'h1010, 1'b0);
    #1 reset = 1'b1;
    repeat (LAT) tick();
    check_eq("post_release", bus.sum, 17'h01F1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
